csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator.sv | 149 ++++++++++++++
 tb/tb_csa_accumulator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Packet accumulator: operands fold into a carry-save total each beat, then the
// pair is resolved RB bits per cycle into a plain binary result.
module csa_accumulator #(
    parameter int W     = 4,
    parameter int N     = 3,
    parameter int ACC_W = 16,
    parameter int RB    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [15:0]        out_beats
);

    localparam int NCH = ACC_W / RB;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [15:0]        beats_q, beats_d;
    logic               carry_q, carry_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [15:0]        out_beats_q, out_beats_d;

    logic [ACC_W-1:0]   tree_s, tree_c, op, maj;
    logic [RB:0]        chunk_sum;

    // Chain of 3:2 compressors; the left shift of the majority vector drops the
    // carry out of the top bit, which is exactly the modulo-2^ACC_W wrap.
    always_comb begin
        tree_s = s_q;
        tree_c = c_q;
        op     = '0;
        maj    = '0;
        for (int k = 0; k < N; k++) begin
            op          = '0;
            op[W-1:0]   = in_data[k*W +: W];
            maj         = (tree_s & tree_c) | (tree_s & op) | (tree_c & op);
            tree_s      = tree_s ^ tree_c ^ op;
            tree_c      = maj << 1;
        end
    end

    always_comb begin
        chunk_sum = {1'b0, s_q[int'(idx_q)*RB +: RB]}
                  + {1'b0, c_q[int'(idx_q)*RB +: RB]}
                  + {{RB{1'b0}}, carry_q};
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        beats_d     = beats_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    s_d     = tree_s;
                    c_d     = tree_c;
                    beats_d = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
                    if (in_last) begin
                        state_d = RESOLVE;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        res_d   = '0;
                    end
                end
            end
            RESOLVE: begin
                res_d[int'(idx_q)*RB +: RB] = chunk_sum[RB-1:0];
                carry_d = chunk_sum[RB];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = OUTPUT;
                    carry_d     = 1'b0;
                    out_valid_d = 1'b1;
                    out_sum_d   = res_d;
                    out_beats_d = beats_q;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    s_d         = '0;
                    c_d         = '0;
                    beats_d     = '0;
                    out_valid_d = 1'b0;
                    out_sum_d   = '0;
                    out_beats_d = '0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            beats_q     <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            beats_q     <= beats_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator with default parameters: directed packets, an
// exhaustive single-beat sweep and randomized packets against an arithmetic model.
module tb_csa_accumulator;

    localparam int W     = 4;
    localparam int N     = 3;
    localparam int ACC_W = 16;
    localparam int RB    = 4;
    localparam int NCH   = ACC_W / RB;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [N*W-1:0]     in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [15:0]        out_beats;

    int n_cmp = 0;
    int n_err = 0;
    longint model_sum = 0;
    int model_beats = 0;

    csa_accumulator #(.W(W), .N(N), .ACC_W(ACC_W), .RB(RB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat after `gap` idle cycles and hold it until accepted.
    task automatic send_beat(input logic [N*W-1:0] d, input bit last, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        for (int k = 0; k < N; k++) model_sum += longint'(d[k*W +: W]);
        model_sum = model_sum % 65536;
        if (model_beats < 65535) model_beats++;
    endtask

    // Wait for the result, check it, hold off the consumer for `hold` cycles,
    // then handshake and check the return to ACCUM.
    task automatic wait_result(input int exp_sum, input int exp_beats, input bit chk_lat, input int hold);
        int edges;
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (chk_lat) check("latency", edges, NCH);
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_sum", {16'd0, out_sum}, exp_sum);
        check("out_beats", {16'd0, out_beats}, exp_beats);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {16'd0, out_sum}, exp_sum);
            check("hold_beats", {16'd0, out_beats}, exp_beats);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_clear", {31'd0, out_valid}, 32'd0);
        check("sum_clear", {16'd0, out_sum}, 32'd0);
        check("beats_clear", {16'd0, out_beats}, 32'd0);
        check("ready_back", {31'd0, in_ready}, 32'd1);
        model_sum   = 0;
        model_beats = 0;
    endtask

    initial begin
        logic [N*W-1:0] d;
        int nb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_beats", {16'd0, out_beats}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 15+15+15 in a single beat
        send_beat({4'd15, 4'd15, 4'd15}, 1'b1, 0);
        wait_result(45, 1, 1'b1, 0);

        // every single-beat operand combination
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 16; c++) begin
                    d = {c[3:0], b[3:0], a[3:0]};
                    send_beat(d, 1'b1, 0);
                    wait_result(a + b + c, 1, 1'b1, 0);
                end

        // 100 beats of 15,15,15
        for (int i = 0; i < 100; i++) send_beat({4'd15, 4'd15, 4'd15}, i == 99, 0);
        check("model_4500", model_sum, 4500);
        wait_result(4500, 100, 1'b1, 0);

        // 1500 beats wrap past 2^16
        for (int i = 0; i < 1500; i++) send_beat({4'd15, 4'd15, 4'd15}, i == 1499, 0);
        check("model_1964", model_sum, 1964);
        wait_result(1964, 1500, 1'b1, 0);

        // backpressure with input activity that must be ignored
        send_beat({4'd3, 4'd9, 4'd11}, 1'b0, 0);
        send_beat({4'd14, 4'd2, 4'd7}, 1'b1, 0);
        repeat (NCH) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = {4'd15, 4'd15, 4'd15};
        in_last  = 1'b1;
        wait_result(46, 2, 1'b0, 10);
        in_last = 1'b0;
        send_beat({4'd7, 4'd6, 4'd5}, 1'b1, 0);
        wait_result(18, 1, 1'b1, 0);

        // reset in the middle of RESOLVE
        send_beat({4'd9, 4'd9, 4'd9}, 1'b1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rr_valid", {31'd0, out_valid}, 32'd0);
        check("rr_sum", {16'd0, out_sum}, 32'd0);
        check("rr_beats", {16'd0, out_beats}, 32'd0);
        check("rr_in_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        model_sum   = 0;
        model_beats = 0;
        send_beat({4'd3, 4'd2, 4'd1}, 1'b1, 0);
        wait_result(6, 1, 1'b1, 0);

        // reset while a result is being presented
        send_beat({4'd8, 4'd8, 4'd8}, 1'b1, 0);
        repeat (NCH) begin
            @(posedge clk);
            #1;
        end
        check("ro_valid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("ro_valid", {31'd0, out_valid}, 32'd0);
        check("ro_sum", {16'd0, out_sum}, 32'd0);
        check("ro_beats", {16'd0, out_beats}, 32'd0);
        check("ro_in_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        model_sum   = 0;
        model_beats = 0;
        send_beat({4'd4, 4'd0, 4'd12}, 1'b1, 0);
        wait_result(16, 1, 1'b1, 0);

        // randomized packets, idle gaps and consumer stalls
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 20);
            for (int i = 0; i < nb; i++) begin
                d = N*W'($urandom);
                send_beat(d, i == nb - 1, $urandom_range(0, 2));
            end
            wait_result(int'(model_sum), model_beats, 1'b1, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
